// File: rtl/aemb_dwb_timer.sv
// Wishbone timer slave: prescaled 32-bit up-counter, compare, auto-reload, level interrupt.
// Define AEMB_TMR_ONESHOT_EN to implement the CTL.OS one-shot bit.
module aemb_dwb_timer #(
    parameter int unsigned PRE_W   = 8,
    parameter logic [31:0] RST_CMP = 32'h00007FFF
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [1:0]  dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_stb_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_wre_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        sys_int_o
);

    localparam logic [31:0] PreMask = ((32'd1 << PRE_W) - 32'd1) << 8;
`ifdef AEMB_TMR_ONESHOT_EN
    localparam logic [31:0] FlagMask = 32'h0000000F;
`else
    localparam logic [31:0] FlagMask = 32'h00000007;
`endif
    localparam logic [31:0] CtlMask = PreMask | FlagMask;

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      cmp_q, cmp_d;
    logic [31:0]      ctl_q, ctl_d;
    logic [PRE_W-1:0] psc_q, psc_d;
    logic             pnd_q, pnd_d;

    logic             bus_acc, wr_en, rd_en;
    logic             en, arl, tick, match;
    logic [PRE_W-1:0] pre;
    logic [31:0]      cnt_tick;
    logic [31:0]      rd_data;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] wr_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = wr_v[8*i +: 8];
        end
        return res;
    endfunction

    assign en  = ctl_q[0];
    assign arl = ctl_q[1];
    assign pre = ctl_q[8 +: PRE_W];

    always_comb begin
        rd_data = 32'd0;
        unique case (dwb_adr_i)
            2'd0: rd_data = cnt_q;
            2'd1: rd_data = cmp_q;
            2'd2: rd_data = ctl_q;
            2'd3: rd_data = {31'd0, pnd_q};
        endcase
    end

    always_comb begin
        bus_acc  = dwb_stb_i & dwb_cyc_i;
        wr_en    = bus_acc & dwb_wre_i & ack_q;
        rd_en    = bus_acc & ~dwb_wre_i & ~ack_q;
        tick     = en && (psc_q == pre);
        match    = tick && (cnt_q == cmp_q);
        cnt_tick = cnt_q;
        if (tick) cnt_tick = (match && arl) ? 32'd0 : cnt_q + 32'd1;

        ack_d = bus_acc & ~ack_q;
        dat_d = rd_en ? rd_data : dat_q;
        cnt_d = cnt_tick;
        cmp_d = cmp_q;
        ctl_d = ctl_q;
        pnd_d = pnd_q;
        psc_d = psc_q;
        if (en) psc_d = tick ? '0 : psc_q + 1'b1;

`ifdef AEMB_TMR_ONESHOT_EN
        if (match && ctl_q[3]) ctl_d[0] = 1'b0;
`endif

        if (wr_en) begin
            unique case (dwb_adr_i)
                2'd0: cnt_d = merge_bytes(cnt_tick, dwb_dat_i, dwb_sel_i);
                2'd1: cmp_d = merge_bytes(cmp_q, dwb_dat_i, dwb_sel_i);
                2'd2: begin
                    // Bus-written EN bytes take precedence over a one-shot stop.
                    ctl_d = merge_bytes(ctl_d, dwb_dat_i, dwb_sel_i) & CtlMask;
                    if (ctl_d[8 +: PRE_W] != pre) psc_d = '0;
                end
                2'd3: if (dwb_sel_i[0] && dwb_dat_i[0]) pnd_d = 1'b0;
            endcase
        end

        if (match) pnd_d = 1'b1;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'd0;
            cnt_q <= 32'd0;
            cmp_q <= RST_CMP;
            ctl_q <= 32'd0;
            psc_q <= '0;
            pnd_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
            cmp_q <= cmp_d;
            ctl_q <= ctl_d;
            psc_q <= psc_d;
            pnd_q <= pnd_d;
        end
    end

    assign dwb_ack_o = ack_q;
    assign dwb_dat_o = dat_q;
    assign sys_int_o = pnd_q & ctl_q[2];

endmodule

// File: tb/tb_aemb_dwb_timer.sv
// Scoreboard bench for aemb_dwb_timer: a behavioural model predicts read data,
// ack and interrupt; a monitor compares on the falling edge.
module tb_aemb_dwb_timer;

    localparam int unsigned PRE_W = 8;
    localparam logic [31:0] RST_CMP = 32'h00007FFF;
    localparam logic [31:0] PRE_MASK = 32'h0000FF00;
`ifdef AEMB_TMR_ONESHOT_EN
    localparam logic [31:0] CTL_MASK = PRE_MASK | 32'h0F;
`else
    localparam logic [31:0] CTL_MASK = PRE_MASK | 32'h07;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        stb, cyc, wre;
    logic [31:0] rdat;
    logic        ack, irq;

    always #5 clk = ~clk;

    aemb_dwb_timer #(.PRE_W(PRE_W), .RST_CMP(RST_CMP)) dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst),
        .dwb_adr_i(adr),
        .dwb_dat_i(wdat),
        .dwb_sel_i(sel),
        .dwb_stb_i(stb),
        .dwb_cyc_i(cyc),
        .dwb_wre_i(wre),
        .dwb_dat_o(rdat),
        .dwb_ack_o(ack),
        .sys_int_o(irq)
    );

    // Reference model state
    logic [31:0] m_cnt, m_cmp, m_ctl, m_dat;
    int unsigned m_psc;
    bit          m_pnd, m_ack, m_rd_ack;
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] bytes_in(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_cnt;
            2'd1:    return m_cmp;
            2'd2:    return m_ctl;
            default: return {31'd0, m_pnd};
        endcase
    endfunction

    always @(posedge clk) begin : model
        int unsigned pre, new_pre;
        bit tick, match, was_ack;
        logic [31:0] cnt_n, ctl_n;
        if (rst) begin
            m_cnt = 0; m_cmp = RST_CMP; m_ctl = 0; m_psc = 0;
            m_pnd = 0; m_ack = 0; m_rd_ack = 0; m_dat = 0;
            exp_q.delete();
        end else begin
            pre   = (m_ctl & PRE_MASK) >> 8;
            tick  = m_ctl[0] && (m_psc == pre);
            match = tick && (m_cnt == m_cmp);
            cnt_n = m_cnt;
            if (tick) cnt_n = (match && m_ctl[1]) ? 32'd0 : m_cnt + 1;
            ctl_n = m_ctl;
            if (match && m_ctl[3]) ctl_n[0] = 1'b0;
            was_ack = m_ack;
            if (m_ctl[0]) m_psc = tick ? 0 : m_psc + 1;
            if (stb && cyc && !was_ack && !wre) begin
                m_dat = model_read(adr);
                exp_q.push_back(m_dat);
                m_rd_ack = 1;
            end else begin
                m_rd_ack = 0;
            end
            if (stb && cyc && wre && was_ack) begin
                case (adr)
                    2'd0: cnt_n = bytes_in(cnt_n, wdat, sel);
                    2'd1: m_cmp = bytes_in(m_cmp, wdat, sel);
                    2'd2: begin
                        ctl_n   = bytes_in(ctl_n, wdat, sel) & CTL_MASK;
                        new_pre = (ctl_n & PRE_MASK) >> 8;
                        if (new_pre != pre) m_psc = 0;
                    end
                    default: if (sel[0] && wdat[0]) m_pnd = 0;
                endcase
            end
            if (match) m_pnd = 1;
            m_cnt = cnt_n;
            m_ctl = ctl_n;
            m_ack = stb && cyc && !was_ack;
        end
    end

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        checks++;
        if (ack !== m_ack) begin
            errors++;
            $display("FAIL ack: got %b want %b at %0t", ack, m_ack, $time);
        end
        checks++;
        if (irq !== (m_pnd & m_ctl[2])) begin
            errors++;
            $display("FAIL sys_int: got %b want %b at %0t", irq, m_pnd & m_ctl[2], $time);
        end
        checks++;
        if (rdat !== m_dat) begin
            errors++;
            $display("FAIL dat_hold: got %h want %h at %0t", rdat, m_dat, $time);
        end
        if (m_ack && m_rd_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_q: got %h want <empty queue> at %0t", rdat, $time);
            end else begin
                e = exp_q.pop_front();
                if (rdat !== e) begin
                    errors++;
                    $display("FAIL read: got %h want %h at %0t", rdat, e, $time);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic xfer(input logic [1:0] a, input logic we, input logic [3:0] s,
                        input logic [31:0] d, input bit abandon);
        adr = a; wre = we; sel = s; wdat = d; stb = 1; cyc = 1;
        step(1);
        if (abandon) begin
            stb = 0;
            cyc = 0;
        end
        step(1);
        stb = 0; cyc = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        xfer(a, 1'b1, s, d, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        xfer(a, 1'b0, 4'hF, $urandom, 1'b0);
    endtask

    initial begin
        logic [1:0]  a;
        logic [31:0] d;
        rst = 1; adr = 0; wdat = 0; sel = 0; stb = 0; cyc = 0; wre = 0;
        step(2);
        rst = 0;
        step(1);

        for (int i = 0; i < 4; i++) rd(i[1:0]);

        wr(2'd1, 4'hF, 32'd3);
        wr(2'd2, 4'hF, 32'h00000007);
        step(12);
        wr(2'd3, 4'hF, 32'd1);
        step(6);
        rd(2'd3);
        rd(2'd0);

        wr(2'd2, 4'hF, 32'h00000301);
        wr(2'd1, 4'hF, 32'hFFFFFFFF);
        rd(2'd2);
        step(9);
        rd(2'd0);

        wr(2'd2, 4'hF, 32'h0);
        wr(2'd3, 4'hF, 32'd1);
        wr(2'd0, 4'hF, 32'hFFFFFFFE);
        wr(2'd1, 4'hF, 32'd5);
        wr(2'd2, 4'hF, 32'd1);
        step(10);
        rd(2'd3);
        rd(2'd0);

        // W1C lands on the match edge, then a byte write on a tick edge
        wr(2'd2, 4'hF, 32'h0);
        wr(2'd3, 4'hF, 32'd1);
        wr(2'd0, 4'hF, 32'h00000010);
        wr(2'd1, 4'hF, 32'h00000011);
        wr(2'd2, 4'hF, 32'd1);
        wr(2'd3, 4'hF, 32'd1);
        rd(2'd3);
        wr(2'd0, 4'h2, 32'h0000AB00);
        rd(2'd0);
        xfer(2'd1, 1'b0, 4'hF, 0, 1'b1);
        xfer(2'd1, 1'b1, 4'hF, 32'h12345678, 1'b1);
        rd(2'd1);

`ifdef AEMB_TMR_ONESHOT_EN
        wr(2'd2, 4'hF, 32'h0);
        wr(2'd0, 4'hF, 32'h0);
        wr(2'd1, 4'hF, 32'd2);
        wr(2'd2, 4'hF, 32'h0000000F);
        step(6);
        rd(2'd2);
        rd(2'd0);
        rd(2'd3);
`endif

        // Reset in the middle of a write
        adr = 2'd0; wre = 1; sel = 4'hF; wdat = 32'hDEADBEEF; stb = 1; cyc = 1;
        step(1);
        rst = 1;
        step(1);
        rst = 0; stb = 0; cyc = 0;
        step(1);
        for (int i = 0; i < 4; i++) rd(i[1:0]);

        for (int i = 0; i < 400; i++) begin
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd2) d &= 32'h0000030F;
            if (a != 2'd2 && a != 2'd3 && $urandom_range(0, 1) == 1) d &= 32'h0000000F;
            xfer(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d,
                 $urandom_range(0, 7) == 0);
            step($urandom_range(0, 3));
        end
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
